pc_fetch_gen: RTL and testbench

//   Parametrised fetch-address generator for the IF stage; successor to the single-width PC register.

---
 rtl/pc_fetch_gen.sv | 140 ++++++++++++++
 tb/tb_pc_fetch_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_gen
// Description : IF-stage fetch-address generator. Presents the next fetch
//               address to instruction memory. The address advances only when
//               a fetch is accepted (ce & pc_read_ready & ~stall). A branch
//               redirect that arrives while imem is not accepting is held as a
//               pending target until it can be issued. A flush (exception)
//               overrides everything except reset. Misaligned addresses are
//               reported but still fetched.
// Ports       : clk, rst                  - clock / synchronous active-high reset
//               stall                     - CTRL stall, blocks acceptance
//               pc_read_ready             - imem took the presented pc
//               branch_flag_i             - single-cycle redirect request
//               branch_target_address_i   - redirect target
//               flush, new_pc             - exception flush and handler address
//               pc                        - fetch address (combinational)
//               ce                        - imem chip enable (registered)
//               redirect_pending_o        - a held branch target is waiting
//               misaligned_o              - pc not FETCH_BYTES aligned while ce=1
//               fetch_count_o             - accepted-fetch counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_gen #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC00000),
  parameter int                FETCH_BYTES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              pc_read_ready,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              redirect_pending_o,
  output logic              misaligned_o,
  output logic [31:0]       fetch_count_o
);

  localparam int                OFS_W = $clog2(FETCH_BYTES);
  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(FETCH_BYTES);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              accept;

  // Request sources are only honoured once ce is up; while ce=0 the
  // registered pc is presented unchanged.
  always_comb begin
    pc = pc_q;
    if (ce_q) begin
      if (flush)              pc = new_pc;
      else if (branch_flag_i) pc = branch_target_address_i;
      else if (pend_q)        pc = tgt_q;
    end
  end

  assign accept = ce_q & pc_read_ready & ~stall;

  always_comb begin
    state_d = state_q;
    ce_d    = ce_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: begin
        // Leaving reset: all requests ignored this cycle, enable imem.
        state_d = ST_RUN;
        ce_d    = 1'b1;
      end
      default: begin
        if (accept) cnt_d = cnt_q + 32'd1;
        if (flush) begin
          pend_d  = 1'b0;
          state_d = ST_RUN;
          pc_d    = accept ? new_pc + INC : new_pc;
        end else if (accept) begin
          // pc already reflects any branch/pending target being issued.
          pc_d    = pc + INC;
          pend_d  = 1'b0;
          state_d = ST_RUN;
        end else if (branch_flag_i) begin
          // Newest redirect wins over an older held one.
          pend_d  = 1'b1;
          tgt_d   = branch_target_address_i;
          state_d = ST_HOLD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      ce_q    <= 1'b0;
      pc_q    <= RESET_VECTOR;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ce                 = ce_q;
  assign redirect_pending_o = pend_q;
  assign fetch_count_o      = cnt_q;

  // Byte-granular fetch has no offset bits, so it can never be misaligned.
  generate
    if (OFS_W == 0) begin : g_no_offset
      assign misaligned_o = 1'b0;
    end else begin : g_offset
      assign misaligned_o = ce_q & (|pc[OFS_W-1:0]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_gen
// Description : Directed table-driven bench for pc_fetch_gen (FETCH_BYTES=4)
//               plus a hand-written sequence on an 8-byte-fetch instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-byte fetch instance
  logic        rst, stall, ready, br, flush;
  logic [31:0] tgt, npc;
  logic [31:0] pc;
  logic        ce, pend, mis;
  logic [31:0] cnt;

  pc_fetch_gen #(.ADDR_W(32), .RESET_VECTOR(32'hBFC00000), .FETCH_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_read_ready(ready),
    .branch_flag_i(br), .branch_target_address_i(tgt),
    .flush(flush), .new_pc(npc),
    .pc(pc), .ce(ce), .redirect_pending_o(pend),
    .misaligned_o(mis), .fetch_count_o(cnt)
  );

  // 8-byte fetch instance
  logic        rst8, stall8, ready8, br8, flush8;
  logic [31:0] tgt8, npc8;
  logic [31:0] pc8;
  logic        ce8, pend8, mis8;
  logic [31:0] cnt8;

  pc_fetch_gen #(.ADDR_W(32), .RESET_VECTOR(32'hBFC00000), .FETCH_BYTES(8)) dut8 (
    .clk(clk), .rst(rst8), .stall(stall8), .pc_read_ready(ready8),
    .branch_flag_i(br8), .branch_target_address_i(tgt8),
    .flush(flush8), .new_pc(npc8),
    .pc(pc8), .ce(ce8), .redirect_pending_o(pend8),
    .misaligned_o(mis8), .fetch_count_o(cnt8)
  );

  typedef struct {
    logic        rst, stall, ready, br, flush;
    logic [31:0] tgt, npc;
    logic        chk;
    logic [31:0] epc;
    logic        ece, epend, emis;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic s, input logic rd, input logic b,
                     input logic [31:0] t, input logic f, input logic [31:0] n,
                     input logic c, input logic [31:0] epc, input logic ece,
                     input logic epend, input logic emis, input logic [31:0] ecnt);
    vec_t v;
    v.rst = r; v.stall = s; v.ready = rd; v.br = b; v.tgt = t;
    v.flush = f; v.npc = n; v.chk = c; v.epc = epc; v.ece = ece;
    v.epend = epend; v.emis = emis; v.ecnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %08h expected %08h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ready = 1'b1; br = 1'b0; flush = 1'b0;
    tgt = '0; npc = '0;
    rst8 = 1'b1; stall8 = 1'b0; ready8 = 1'b0; br8 = 1'b0; flush8 = 1'b0;
    tgt8 = '0; npc8 = '0;

    //   rst stl rdy br tgt           fl npc           chk pc            ce pnd mis cnt
    // reset for 3 cycles, then release and sequential fetch
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00000, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00000, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00000, 1, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00004, 1, 0, 0, 1);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00008, 1, 0, 0, 2);
    // branch while imem busy -> held, then issued
    add(0, 0, 0, 1, 32'h80001000, 0, 32'h0,        1, 32'h80001000, 1, 0, 0, 2);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80001000, 1, 1, 0, 2);
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h80001000, 1, 1, 0, 2);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80001004, 1, 0, 0, 3);
    // flush beats a simultaneous branch, accepted in the same cycle
    add(0, 0, 1, 1, 32'h12345678, 1, 32'hBFC00380, 1, 32'hBFC00380, 1, 0, 0, 3);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00384, 1, 0, 0, 4);
    // flush without accept loads new_pc as-is, then stall for 4 cycles
    add(0, 0, 0, 0, 32'h0,        1, 32'hBFC00010, 1, 32'hBFC00010, 1, 0, 0, 4);
    add(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00010, 1, 0, 0, 4);
    add(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00010, 1, 0, 0, 4);
    add(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00010, 1, 0, 0, 4);
    add(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00010, 1, 0, 0, 4);
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00010, 1, 0, 0, 4);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00014, 1, 0, 0, 5);
    // branch during stall is held; a newer branch overwrites it
    add(0, 1, 1, 1, 32'h80003000, 0, 32'h0,        1, 32'h80003000, 1, 0, 0, 5);
    add(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h80003000, 1, 1, 0, 5);
    add(0, 0, 0, 1, 32'h80004000, 0, 32'h0,        1, 32'h80004000, 1, 1, 0, 5);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80004000, 1, 1, 0, 5);
    // reset while holding discards the pending target
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00000, 0, 0, 0, 0);
    add(0, 0, 1, 1, 32'h80002000, 1, 32'h11111110, 1, 32'hBFC00000, 0, 0, 0, 0);
    // address wrap FFFFFFFC + 4 -> 0, not flagged
    add(0, 0, 1, 0, 32'h0,        1, 32'hFFFFFFF8, 1, 32'hFFFFFFF8, 1, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 1, 0, 0, 1);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h00000000, 1, 0, 0, 2);
    // misaligned target still fetched and advanced
    add(0, 0, 0, 1, 32'h80000002, 0, 32'h0,        1, 32'h80000002, 1, 0, 1, 2);
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h80000002, 1, 1, 1, 2);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000006, 1, 0, 1, 3);

    @(posedge clk); #1;
    foreach (vq[i]) begin
      rst = vq[i].rst; stall = vq[i].stall; ready = vq[i].ready;
      br = vq[i].br; tgt = vq[i].tgt; flush = vq[i].flush; npc = vq[i].npc;
      @(negedge clk);
      if (vq[i].chk) begin
        cmp("pc",    i, pc,  vq[i].epc);
        cmp("ce",    i, {31'd0, ce},   {31'd0, vq[i].ece});
        cmp("pend",  i, {31'd0, pend}, {31'd0, vq[i].epend});
        cmp("mis",   i, {31'd0, mis},  {31'd0, vq[i].emis});
        cmp("count", i, cnt, vq[i].ecnt);
      end
      @(posedge clk); #1;
    end

    // 8-byte fetch build: 80000004 is misaligned here
    rst8 = 1'b0;
    @(negedge clk);
    cmp("ce8_rel", 100, {31'd0, ce8}, 32'd0);
    @(posedge clk); #1;
    br8 = 1'b1; tgt8 = 32'h80000004; ready8 = 1'b0;
    @(negedge clk);
    cmp("pc8_br",  101, pc8, 32'h80000004);
    cmp("mis8_br", 101, {31'd0, mis8}, 32'd1);
    @(posedge clk); #1;
    br8 = 1'b0; ready8 = 1'b1;
    @(negedge clk);
    cmp("pc8_hold",   102, pc8, 32'h80000004);
    cmp("pend8_hold", 102, {31'd0, pend8}, 32'd1);
    cmp("mis8_hold",  102, {31'd0, mis8}, 32'd1);
    @(posedge clk); #1;
    ready8 = 1'b0;
    @(negedge clk);
    cmp("pc8_next",   103, pc8, 32'h8000000C);
    cmp("mis8_next",  103, {31'd0, mis8}, 32'd1);
    cmp("cnt8_next",  103, cnt8, 32'd1);
    cmp("pend8_next", 103, {31'd0, pend8}, 32'd0);
    @(posedge clk); #1;
    br8 = 1'b1; tgt8 = 32'h80000010;
    @(negedge clk);
    cmp("pc8_al",  104, pc8, 32'h80000010);
    cmp("mis8_al", 104, {31'd0, mis8}, 32'd0);
    @(posedge clk); #1;
    br8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
